window_stats_collector: RTL and testbench
=========================================

Name: window_stats_collector

Overview:
- Consumes the per-cycle two's-complement sample stream produced by the sign-conversion stage during one enable window of N cycles.
- Accumulates the window's signed sum, minimum and maximum, and registers a mean.
- Presents the results under a valid/ack handshake to the bus-side reader.
- Sits directly downstream of the sign-conversion stage and shares its enable and finish signals.

Parameters:
DW, 32, sample width (two's complement)
N, 64, samples per window; power of two, at least 2
CW, $clog2(N), derived; count and sum growth bits
SW, DW+CW, derived; accumulator width

Ports:
iClk  in  1  clock; all state changes on rising edge
iRst_n  in  1  synchronous active-low reset
iEnable  in  1  window enable; same signal that drives the upstream stage
iData  in  DW  converted sample, valid every cycle iEnable=1
iFinish  in  1  upstream last-sample flag, high on sample N-1
iAck  in  1  reader acknowledge of result
oValid  out  1  result registers hold a completed window
oSum  out  SW  signed sum of window samples
oMin  out  DW  signed minimum sample
oMax  out  DW  signed maximum sample
oMean  out  DW  oSum arithmetic-shifted right by CW, truncated to DW
oCount  out  CW+1  samples captured in the last completed window
oMismatch  out  1  iFinish position disagreed with the internal count in the last window
oAbort  out  1  one-cycle pulse: window dropped before completion
oBusy  out  1  high in ACC state

Behaviour:
- Reset: when iRst_n=0 at a clock edge, state goes to IDLE and all outputs and accumulators go to 0. Reset takes priority over every other event, including mid-window and in HOLD; a partial window is discarded with no oAbort.
- States: IDLE, ACC, HOLD, WAIT_LOW.
- IDLE: on iEnable=1, the current cycle is sample 0. Load sum with the sign-extended iData, min=max=iData, idx=1, then go to ACC. Otherwise stay in IDLE.
- ACC, iEnable=1: add the sign-extended iData to sum (SW bits, no saturation; SW cannot overflow for N samples). Update min/max with signed compare. Increment idx.
- ACC completion: the sample on which iFinish=1 or idx==N-1, whichever comes first, is accumulated and ends the window.
  - Next edge: register oSum, oMin, oMax, oMean from post-update values; oCount = idx+1.
  - oMismatch = 1 if iFinish and idx==N-1 were not both true on that sample.
  - oValid goes to 1 and the state moves to HOLD.
  - Latency: results visible 1 cycle after the last sample.
- ACC, iEnable=0 before completion: go to IDLE. oAbort = 1 for exactly one cycle. Accumulators are cleared. Result registers keep the previous window's values, and oValid stays 0.
- HOLD: outputs stable, iData/iFinish/iEnable ignored (upstream keeps enable high after finish).
  - On iAck=1: oValid goes to 0 next cycle.
  - Then go to WAIT_LOW if iEnable=1, else IDLE.
  - iAck outside HOLD is ignored.
- WAIT_LOW: stay until iEnable=0, then go to IDLE. No new window can start until enable has been seen low, so a held enable never re-triggers capture.
- oBusy = 1 only in ACC (registered, aligned with the state).
- Result registers change only on completion or reset.

Test Plan:
- Ramp: reset, iEnable high 64 cycles, iData = 0..63, iFinish on the 64th sample -> 1 cycle later:
  - oValid=1, oSum=2016, oMin=0, oMax=63, oMean=31, oCount=64, oMismatch=0.
- Negatives: iData = -1 (0xFFFFFFFF) for all 64 samples -> oSum = -64 sign-extended to SW bits, oMin=oMax=0xFFFFFFFF, oMean=0xFFFFFFFF.
- Abort: iEnable drops after 10 samples ->
  - oAbort high exactly 1 cycle, oValid=0, result registers unchanged.
  - A following full window completes normally.
- Early finish: iFinish on sample 39 -> oCount=40, oMismatch=1.
- Handshake:
  - iAck held 0 for 20 cycles in HOLD, with random iData and enable high -> outputs constant.
  - iAck=1 with enable still high -> oValid=0 next cycle and state WAIT_LOW.
  - Enable held 5 more cycles -> no capture.
  - Enable low, then a new window -> capture restarts.
- Reset mid-window: iRst_n=0 for 1 cycle at sample 30 -> all outputs 0 on the following cycle, no oAbort, IDLE.

Source files
------------

// File: rtl/window_stats_collector.sv
// Per-window statistics over the sign-converted sample stream: signed sum, min, max
// and mean, handed to the bus-side reader under a valid/ack handshake.
module window_stats_collector #(
  parameter int DW = 32,
  parameter int N  = 64,
  parameter int CW = $clog2(N),
  parameter int SW = DW + CW
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iEnable,
  input  logic [DW-1:0] iData,
  input  logic          iFinish,
  input  logic          iAck,
  output logic          oValid,
  output logic [SW-1:0] oSum,
  output logic [DW-1:0] oMin,
  output logic [DW-1:0] oMax,
  output logic [DW-1:0] oMean,
  output logic [CW:0]   oCount,
  output logic          oMismatch,
  output logic          oAbort,
  output logic          oBusy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD,
    S_WAIT_LOW
  } state_t;

  localparam logic [CW-1:0] LP_LAST = CW'(N - 1);

  state_t r_state;
  state_t w_state_nx;

  logic [SW-1:0] r_acc_sum;
  logic [DW-1:0] r_acc_min;
  logic [DW-1:0] r_acc_max;
  logic [CW-1:0] r_idx;

  logic [SW-1:0] r_sum;
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_max;
  logic [DW-1:0] r_mean;
  logic [CW:0]   r_count;
  logic          r_mism;
  logic          r_valid;
  logic          r_abort;

  logic [SW-1:0] w_sext;
  logic [SW-1:0] w_sum_nx;
  logic [DW-1:0] w_min_nx;
  logic [DW-1:0] w_max_nx;
  logic          w_last;
  logic          w_done;

  assign w_sext   = {{CW{iData[DW-1]}}, iData};
  assign w_sum_nx = r_acc_sum + w_sext;
  assign w_min_nx = ($signed(iData) < $signed(r_acc_min)) ? iData : r_acc_min;
  assign w_max_nx = ($signed(iData) > $signed(r_acc_max)) ? iData : r_acc_max;
  assign w_last   = (r_idx == LP_LAST);
  assign w_done   = iFinish || w_last;

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (iEnable) begin
          w_state_nx = S_ACC;
        end
      end
      S_ACC: begin
        if (!iEnable) begin
          w_state_nx = S_IDLE;
        end else if (w_done) begin
          w_state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (iAck) begin
          w_state_nx = iEnable ? S_WAIT_LOW : S_IDLE;
        end
      end
      S_WAIT_LOW: begin
        if (!iEnable) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    oBusy = (r_state == S_ACC);
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_acc_sum <= '0;
      r_acc_min <= '0;
      r_acc_max <= '0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_mean    <= '0;
      r_count   <= '0;
      r_mism    <= 1'b0;
      r_valid   <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iEnable) begin
            r_acc_sum <= w_sext;
            r_acc_min <= iData;
            r_acc_max <= iData;
            r_idx     <= CW'(1);
          end
        end
        S_ACC: begin
          if (!iEnable) begin
            r_abort   <= 1'b1;
            r_acc_sum <= '0;
            r_acc_min <= '0;
            r_acc_max <= '0;
            r_idx     <= '0;
          end else if (w_done) begin
            // SW = DW + CW, so the arithmetic shift by CW truncated to DW is the top DW bits.
            r_sum     <= w_sum_nx;
            r_min     <= w_min_nx;
            r_max     <= w_max_nx;
            r_mean    <= w_sum_nx[SW-1:CW];
            r_count   <= (CW+1)'(r_idx) + (CW+1)'(1);
            r_mism    <= !(iFinish && w_last);
            r_valid   <= 1'b1;
            r_acc_sum <= '0;
            r_acc_min <= '0;
            r_acc_max <= '0;
            r_idx     <= '0;
          end else begin
            r_acc_sum <= w_sum_nx;
            r_acc_min <= w_min_nx;
            r_acc_max <= w_max_nx;
            r_idx     <= r_idx + CW'(1);
          end
        end
        S_HOLD: begin
          if (iAck) begin
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign oValid    = r_valid;
  assign oSum      = r_sum;
  assign oMin      = r_min;
  assign oMax      = r_max;
  assign oMean     = r_mean;
  assign oCount    = r_count;
  assign oMismatch = r_mism;
  assign oAbort    = r_abort;

endmodule

// File: tb/tb_window_stats_collector.sv
// Randomised bench for window_stats_collector; a queue-based window model supplies
// every expected output on every cycle.
module tb_window_stats_collector;

  localparam int DW = 32;
  localparam int N  = 64;
  localparam int CW = 6;
  localparam int SW = DW + CW;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] data;
  logic          fin;
  logic          ack;

  logic          oValid;
  logic [SW-1:0] oSum;
  logic [DW-1:0] oMin;
  logic [DW-1:0] oMax;
  logic [DW-1:0] oMean;
  logic [CW:0]   oCount;
  logic          oMismatch;
  logic          oAbort;
  logic          oBusy;

  window_stats_collector #(
    .DW(DW),
    .N (N)
  ) dut (
    .iClk     (clk),
    .iRst_n   (rst_n),
    .iEnable  (en),
    .iData    (data),
    .iFinish  (fin),
    .iAck     (ack),
    .oValid   (oValid),
    .oSum     (oSum),
    .oMin     (oMin),
    .oMax     (oMax),
    .oMean    (oMean),
    .oCount   (oCount),
    .oMismatch(oMismatch),
    .oAbort   (oAbort),
    .oBusy    (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected outputs
  logic          e_valid, e_mism, e_abort, e_busy;
  logic [SW-1:0] e_sum;
  logic [DW-1:0] e_min, e_max, e_mean;
  int            e_count;

  // Window model: samples collected so far plus a coarse protocol phase
  logic [DW-1:0] q[$];
  bit            m_win, m_hold, m_wait;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic finalize_window();
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] sh;
    logic signed [DW-1:0] mn, mx;
    s  = '0;
    mn = $signed(q[0]);
    mx = $signed(q[0]);
    foreach (q[i]) begin
      s = s + $signed(q[i]);
      if ($signed(q[i]) < mn) mn = $signed(q[i]);
      if ($signed(q[i]) > mx) mx = $signed(q[i]);
    end
    sh      = s >>> CW;
    e_sum   = s;
    e_min   = mn;
    e_max   = mx;
    e_mean  = sh[DW-1:0];
    e_count = q.size();
    e_mism  = !(fin && (q.size() == N));
    e_valid = 1'b1;
  endtask

  task automatic model_step();
    e_abort = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_win = 0; m_hold = 0; m_wait = 0;
      e_valid = 0; e_sum = '0; e_min = '0; e_max = '0; e_mean = '0;
      e_count = 0; e_mism = 0;
    end else if (m_hold) begin
      if (ack) begin
        e_valid = 1'b0;
        m_hold  = 0;
        m_wait  = en;
      end
    end else if (m_wait) begin
      if (!en) m_wait = 0;
    end else if (!m_win) begin
      if (en) begin
        q.delete();
        q.push_back(data);
        m_win = 1;
      end
    end else if (!en) begin
      e_abort = 1'b1;
      q.delete();
      m_win = 0;
    end else begin
      q.push_back(data);
      if (fin || q.size() == N) begin
        finalize_window();
        q.delete();
        m_win  = 0;
        m_hold = 1;
      end
    end
    e_busy = m_win;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("valid", 64'(oValid), 64'(e_valid));
    check_eq("sum", 64'(oSum), 64'(e_sum));
    check_eq("min", 64'(oMin), 64'(e_min));
    check_eq("max", 64'(oMax), 64'(e_max));
    check_eq("mean", 64'(oMean), 64'(e_mean));
    check_eq("count", 64'(oCount), 64'(e_count));
    check_eq("mismatch", 64'(oMismatch), 64'(e_mism));
    check_eq("abort", 64'(oAbort), 64'(e_abort));
    check_eq("busy", 64'(oBusy), 64'(e_busy));
  endtask

  task automatic apply(input logic e, input logic [DW-1:0] d, input logic f, input logic a);
    en = e; data = d; fin = f; ack = a;
    tick();
  endtask

  initial begin
    logic [DW-1:0] v;
    int            k, mode, dly;

    rst_n = 1'b0; en = 1'b0; data = '0; fin = 1'b0; ack = 1'b0;
    apply(0, '0, 0, 0);
    apply(0, '0, 0, 0);
    check_eq("rst_valid", 64'(oValid), 64'(0));
    check_eq("rst_sum", 64'(oSum), 64'(0));
    rst_n = 1'b1;
    apply(0, '0, 0, 1);

    // Ramp window
    for (int i = 0; i < N; i++) apply(1, DW'(i), i == N - 1, 0);
    check_eq("ramp_valid", 64'(oValid), 64'(1));
    check_eq("ramp_sum", 64'(oSum), 64'(2016));
    check_eq("ramp_min", 64'(oMin), 64'(0));
    check_eq("ramp_max", 64'(oMax), 64'(63));
    check_eq("ramp_mean", 64'(oMean), 64'(31));
    check_eq("ramp_count", 64'(oCount), 64'(64));
    check_eq("ramp_mism", 64'(oMismatch), 64'(0));

    // Hold with enable high and no ack
    for (int i = 0; i < 20; i++) begin
      apply(1, $urandom, 1'($urandom), 0);
      check_eq("hold_sum", 64'(oSum), 64'(2016));
    end
    apply(1, $urandom, 0, 1);
    check_eq("ack_valid", 64'(oValid), 64'(0));
    for (int i = 0; i < 5; i++) begin
      apply(1, $urandom, 0, 0);
      check_eq("waitlow_busy", 64'(oBusy), 64'(0));
    end
    apply(0, '0, 0, 0);

    // All-negative window
    for (int i = 0; i < N; i++) apply(1, '1, i == N - 1, 0);
    check_eq("neg_sum", 64'(oSum), 64'({6'h3F, 32'hFFFF_FFC0}));
    check_eq("neg_min", 64'(oMin), 64'(32'hFFFF_FFFF));
    check_eq("neg_max", 64'(oMax), 64'(32'hFFFF_FFFF));
    check_eq("neg_mean", 64'(oMean), 64'(32'hFFFF_FFFF));
    apply(0, '0, 0, 1);

    // Abort after 10 samples
    for (int i = 0; i < 10; i++) apply(1, $urandom, 0, 0);
    apply(0, '0, 0, 0);
    check_eq("abort_pulse", 64'(oAbort), 64'(1));
    check_eq("abort_valid", 64'(oValid), 64'(0));
    check_eq("abort_keep_sum", 64'(oSum), 64'({6'h3F, 32'hFFFF_FFC0}));
    apply(0, '0, 0, 0);
    check_eq("abort_once", 64'(oAbort), 64'(0));
    for (int i = 0; i < N; i++) apply(1, $urandom, i == N - 1, 0);
    check_eq("after_abort_valid", 64'(oValid), 64'(1));
    apply(0, '0, 0, 1);

    // Early finish on sample 39
    for (int i = 0; i < 40; i++) apply(1, $urandom, i == 39, 0);
    check_eq("early_count", 64'(oCount), 64'(40));
    check_eq("early_mism", 64'(oMismatch), 64'(1));
    apply(0, '0, 0, 1);

    // Reset at sample 30
    for (int i = 0; i < 30; i++) apply(1, $urandom, 0, 0);
    rst_n = 1'b0;
    apply(1, $urandom, 0, 0);
    rst_n = 1'b1;
    check_eq("midrst_valid", 64'(oValid), 64'(0));
    check_eq("midrst_sum", 64'(oSum), 64'(0));
    check_eq("midrst_count", 64'(oCount), 64'(0));
    check_eq("midrst_abort", 64'(oAbort), 64'(0));
    check_eq("midrst_busy", 64'(oBusy), 64'(0));
    apply(0, '0, 0, 0);

    // Randomised windows: full, early finish, missing finish, abort
    for (int w = 0; w < 16; w++) begin
      mode = $urandom_range(0, 3);
      k    = $urandom_range(1, N - 2);
      case (mode)
        0: for (int i = 0; i < N; i++) apply(1, $urandom, i == N - 1, 1'($urandom));
        1: for (int i = 0; i <= k; i++) apply(1, $urandom, i == k, 1'($urandom));
        2: for (int i = 0; i < N; i++) apply(1, $urandom, 0, 1'($urandom));
        default: begin
          for (int i = 0; i < k; i++) apply(1, $urandom, 0, 1'($urandom));
          apply(0, $urandom, 0, 0);
        end
      endcase
      if (mode != 3) begin
        dly = $urandom_range(0, 4);
        for (int i = 0; i < dly; i++) apply(1, $urandom, 1'($urandom), 0);
        v = $urandom;
        apply(v[0], $urandom, 0, 1);
        dly = $urandom_range(0, 3);
        for (int i = 0; i < dly; i++) apply(1, $urandom, 0, 1'($urandom));
      end
      apply(0, '0, 0, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
